// File: rtl/wb_cmd_initiator_if.sv
// Command/response stream channels plus Wishbone classic bus of the command initiator.
// master = initiator side, slave = command source, response sink and Wishbone target.
interface wb_cmd_initiator_if;
    logic [63:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [33:0] rsp_tdata;
    logic        rsp_tvalid;
    logic        rsp_tready;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        input  cmd_tdata, cmd_tvalid, rsp_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output cmd_tready, rsp_tdata, rsp_tvalid,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output cmd_tdata, cmd_tvalid, rsp_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  cmd_tready, rsp_tdata, rsp_tvalid,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic initiator: one command in flight, bounded retry on rty and a per-attempt
// timeout, result returned on a response stream.
module wb_cmd_initiator #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_cmd_initiator_if.master bus
);
    localparam int unsigned TW = 16;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_ACK = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTX = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {IDLE, CYCLE, BACKOFF, RESP} state_t;

    state_t         state;
    logic [TW-1:0]  tmo_cnt;
    logic [RW-1:0]  retry_cnt;

    logic           cyc_done_c;
    logic           cyc_retry_c;
    logic [1:0]     cyc_status_c;
    logic [31:0]    cyc_rdata_c;

    logic           unused_cmd_bits;
    assign unused_cmd_bits = ^bus.cmd_tdata[62:58];

    // Termination decode for the current attempt: err > rty > ack > timeout.
    always_comb begin
        cyc_done_c   = 1'b0;
        cyc_retry_c  = 1'b0;
        cyc_status_c = ST_ACK;
        cyc_rdata_c  = '0;
        if (bus.wb_err_i) begin
            cyc_done_c   = 1'b1;
            cyc_status_c = ST_ERR;
        end else if (bus.wb_rty_i) begin
            if (retry_cnt == RW'(MAX_RETRY)) begin
                cyc_done_c   = 1'b1;
                cyc_status_c = ST_RTX;
            end else begin
                cyc_retry_c  = 1'b1;
            end
        end else if (bus.wb_ack_i) begin
            cyc_done_c   = 1'b1;
            cyc_status_c = ST_ACK;
            cyc_rdata_c  = bus.wb_we_o ? 32'h0 : bus.wb_dat_i;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            cyc_done_c   = 1'b1;
            cyc_status_c = ST_TMO;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            tmo_cnt        <= '0;
            retry_cnt      <= '0;
            bus.cmd_tready <= 1'b0;
            bus.rsp_tvalid <= 1'b0;
            bus.rsp_tdata  <= '0;
            bus.wb_cyc_o   <= 1'b0;
            bus.wb_stb_o   <= 1'b0;
            bus.wb_we_o    <= 1'b0;
            bus.wb_adr_o   <= '0;
            bus.wb_dat_o   <= '0;
            bus.wb_sel_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cmd_tready <= 1'b1;
                    if (bus.cmd_tvalid && bus.cmd_tready) begin
                        bus.cmd_tready <= 1'b0;
                        bus.wb_we_o    <= bus.cmd_tdata[63];
                        bus.wb_sel_o   <= bus.cmd_tdata[57:54];
                        bus.wb_adr_o   <= bus.cmd_tdata[53:32];
                        bus.wb_dat_o   <= bus.cmd_tdata[31:0];
                        bus.wb_cyc_o   <= 1'b1;
                        bus.wb_stb_o   <= 1'b1;
                        tmo_cnt        <= '0;
                        retry_cnt      <= '0;
                        state          <= CYCLE;
                    end
                end
                CYCLE: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (cyc_done_c) begin
                        bus.wb_cyc_o   <= 1'b0;
                        bus.wb_stb_o   <= 1'b0;
                        bus.rsp_tvalid <= 1'b1;
                        bus.rsp_tdata  <= {cyc_status_c, cyc_rdata_c};
                        state          <= RESP;
                    end else if (cyc_retry_c) begin
                        bus.wb_cyc_o <= 1'b0;
                        bus.wb_stb_o <= 1'b0;
                        retry_cnt    <= retry_cnt + RW'(1);
                        state        <= BACKOFF;
                    end
                end
                // One idle bus cycle between attempts; each attempt gets a fresh window.
                BACKOFF: begin
                    tmo_cnt      <= '0;
                    bus.wb_cyc_o <= 1'b1;
                    bus.wb_stb_o <= 1'b1;
                    state        <= CYCLE;
                end
                RESP: begin
                    if (bus.rsp_tready) begin
                        bus.rsp_tvalid <= 1'b0;
                        bus.cmd_tready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator: scripted/random Wishbone target, transaction-level model of the
// expected bus timeline and response, per-cycle compare process.
module tb_wb_cmd_initiator;
    localparam int unsigned TMO  = 8;
    localparam int unsigned MR   = 3;
    localparam int unsigned NATT = MR + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_cmd_initiator_if bus();

    wb_cmd_initiator #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction script: per attempt, the cycle index of termination and which signals fire.
    int unsigned s_wait [NATT];
    logic [2:0]  s_mask [NATT];
    logic [31:0] s_rdat [NATT];
    logic        s_we;
    logic [21:0] s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;

    logic [1:0]  m_status;
    logic [31:0] m_data;
    int          m_natt;
    int unsigned m_len [NATT];

    logic        chk_en   = 1'b0;
    logic        e_cyc    = 1'b0;
    logic        e_tready = 1'b0;
    logic        e_rv     = 1'b0;
    logic [33:0] e_rsp    = '0;
    logic [33:0] cap_rsp  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Outcome of a transaction from the target script: attempts used, their lengths, result.
    task automatic compute_model();
        logic done;
        done = 1'b0;
        m_natt = 0;
        m_status = 2'b00;
        m_data = '0;
        for (int k = 0; k < int'(NATT); k++) m_len[k] = 0;
        for (int k = 0; k < int'(NATT); k++) begin
            if (!done) begin
                m_natt = k + 1;
                if (s_wait[k] >= TMO) begin
                    m_len[k] = TMO; m_status = 2'b11; m_data = '0; done = 1'b1;
                end else begin
                    m_len[k] = s_wait[k] + 1;
                    if (s_mask[k][2]) begin
                        m_status = 2'b01; m_data = '0; done = 1'b1;
                    end else if (s_mask[k][1]) begin
                        if (k == int'(MR)) begin m_status = 2'b10; m_data = '0; done = 1'b1; end
                    end else begin
                        m_status = 2'b00; m_data = s_we ? 32'h0 : s_rdat[k]; done = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc", 64'(bus.wb_cyc_o), 64'(e_cyc));
            check("stb", 64'(bus.wb_stb_o), 64'(e_cyc));
            check("cmd_tready", 64'(bus.cmd_tready), 64'(e_tready));
            check("rsp_tvalid", 64'(bus.rsp_tvalid), 64'(e_rv));
            if (e_cyc) begin
                check("adr", 64'(bus.wb_adr_o), 64'(s_adr));
                check("dat_o", 64'(bus.wb_dat_o), 64'(s_dat));
                check("sel", 64'(bus.wb_sel_o), 64'(s_sel));
                check("we", 64'(bus.wb_we_o), 64'(s_we));
            end
            if (e_rv) check("rsp_tdata", 64'(bus.rsp_tdata), 64'(e_rsp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_spurious();
        logic [2:0] m;
        m = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
        {bus.wb_err_i, bus.wb_rty_i, bus.wb_ack_i} = m;
        bus.wb_dat_i = $urandom;
    endtask

    task automatic drive_term(input logic [2:0] m, input logic [31:0] d);
        {bus.wb_err_i, bus.wb_rty_i, bus.wb_ack_i} = m;
        bus.wb_dat_i = d;
    endtask

    task automatic set_cmd(input logic we, input logic [21:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        s_we = we; s_adr = adr; s_dat = dat; s_sel = sel;
        for (int k = 0; k < int'(NATT); k++) begin
            s_wait[k] = 0; s_mask[k] = 3'b001; s_rdat[k] = $urandom;
        end
    endtask

    task automatic set_att(input int k, input int unsigned w, input logic [2:0] m,
                           input logic [31:0] d);
        s_wait[k] = w; s_mask[k] = m; s_rdat[k] = d;
    endtask

    // Drives one transaction from an idle DUT through the response handshake.
    task automatic run_txn(input int hold);
        compute_model();
        repeat ($urandom_range(0, 2)) begin
            bus.cmd_tvalid = 1'b0; drive_spurious(); step();
        end
        bus.cmd_tdata  = {s_we, 5'($urandom), s_sel, s_adr, s_dat};
        bus.cmd_tvalid = 1'b1;
        drive_spurious();
        step();
        bus.cmd_tvalid = 1'b0;
        bus.cmd_tdata  = {$urandom, $urandom};
        e_tready = 1'b0;
        for (int k = 0; k < m_natt; k++) begin
            for (int unsigned c = 0; c < m_len[k]; c++) begin
                e_cyc = 1'b1;
                if (c == s_wait[k]) drive_term(s_mask[k], s_rdat[k]);
                else drive_term(3'b000, $urandom);
                step();
            end
            e_cyc = 1'b0;
            if (k < m_natt - 1) begin
                drive_spurious(); step();
            end
        end
        e_rv  = 1'b1;
        e_rsp = {m_status, m_data};
        cap_rsp = bus.rsp_tdata;
        for (int h = 0; h < hold; h++) begin
            bus.rsp_tready = 1'b0; drive_spurious(); step();
        end
        bus.rsp_tready = 1'b1;
        drive_spurious();
        step();
        bus.rsp_tready = 1'($urandom);
        e_rv = 1'b0;
        e_tready = 1'b1;
    endtask

    initial begin
        bus.cmd_tdata = '0; bus.cmd_tvalid = 1'b0; bus.rsp_tready = 1'b0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        check("rst_tready", 64'(bus.cmd_tready), 64'd0);
        check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("rst_rvalid", 64'(bus.rsp_tvalid), 64'd0);
        rst = 1'b0;
        #1;
        check("tready_before_edge", 64'(bus.cmd_tready), 64'd0);
        step();
        check("tready_after_release", 64'(bus.cmd_tready), 64'd1);
        e_cyc = 1'b0; e_tready = 1'b1; e_rv = 1'b0;
        chk_en = 1'b1;

        set_cmd(1'b1, 22'h000010, 32'hDEADBEEF, 4'hF);
        run_txn(2);
        check("write_len", 64'(m_len[0]), 64'd1);
        check("write_rsp", 64'(cap_rsp), 64'h0);

        set_cmd(1'b0, 22'h000084, 32'h0, 4'hF);
        set_att(0, 3, 3'b001, 32'h12345678);
        run_txn(10);
        check("read_len", 64'(m_len[0]), 64'd4);
        check("read_rsp", 64'(cap_rsp), 64'h0_1234_5678);

        set_cmd(1'b0, 22'h000100, 32'h0, 4'h3);
        set_att(0, 0, 3'b010, 32'h0);
        set_att(1, 0, 3'b010, 32'h0);
        set_att(2, 2, 3'b001, 32'hA5A5A5A5);
        run_txn(1);
        check("retry_attempts", 64'(m_natt), 64'd3);
        check("retry_rsp", 64'(cap_rsp), 64'h0_A5A5_A5A5);

        set_cmd(1'b1, 22'h000200, 32'h55AA55AA, 4'h1);
        for (int k = 0; k < int'(NATT); k++) set_att(k, 1, 3'b010, 32'h0);
        run_txn(0);
        check("rtx_attempts", 64'(m_natt), 64'd4);
        check("rtx_rsp", 64'(cap_rsp), 64'h2_0000_0000);

        set_cmd(1'b0, 22'h000300, 32'h0, 4'hF);
        set_att(0, 100, 3'b001, 32'h11111111);
        run_txn(1);
        check("tmo_len", 64'(m_len[0]), 64'd8);
        check("tmo_rsp", 64'(cap_rsp), 64'h3_0000_0000);

        set_cmd(1'b1, 22'h3FFFFF, 32'h01234567, 4'h3);
        run_txn(0);
        check("after_tmo_rsp", 64'(cap_rsp), 64'h0);

        set_cmd(1'b0, 22'h000020, 32'h0, 4'hF);
        set_att(0, 1, 3'b101, 32'h77777777);
        run_txn(0);
        check("ack_err_rsp", 64'(cap_rsp), 64'h1_0000_0000);

        set_cmd(1'b0, 22'h000024, 32'h0, 4'hF);
        set_att(0, 7, 3'b001, 32'hCAFEF00D);
        run_txn(0);
        check("ack_at_tmo_len", 64'(m_len[0]), 64'd8);
        check("ack_at_tmo_rsp", 64'(cap_rsp), 64'h0_CAFE_F00D);

        for (int t = 0; t < 60; t++) begin
            set_cmd(1'($urandom), 22'($urandom), $urandom, 4'($urandom));
            for (int k = 0; k < int'(NATT); k++)
                set_att(k, $urandom_range(0, 10), 3'($urandom_range(1, 7)), $urandom);
            run_txn($urandom_range(0, 3));
        end

        // Reset in the middle of a read attempt.
        set_cmd(1'b0, 22'h000040, 32'h0, 4'hF);
        set_att(0, 100, 3'b001, 32'h0);
        bus.cmd_tdata  = {s_we, 5'd0, s_sel, s_adr, s_dat};
        bus.cmd_tvalid = 1'b1;
        drive_term(3'b000, 32'h0);
        step();
        bus.cmd_tvalid = 1'b0;
        e_cyc = 1'b1; e_tready = 1'b0;
        repeat (2) step();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("async_rst_stb", 64'(bus.wb_stb_o), 64'd0);
        check("async_rst_rvalid", 64'(bus.rsp_tvalid), 64'd0);
        check("async_rst_tready", 64'(bus.cmd_tready), 64'd0);
        repeat (2) step();
        rst = 1'b0;
        check("release_tready_pre", 64'(bus.cmd_tready), 64'd0);
        step();
        check("release_tready_post", 64'(bus.cmd_tready), 64'd1);
        e_cyc = 1'b0; e_tready = 1'b1; e_rv = 1'b0;
        chk_en = 1'b1;
        repeat (6) begin
            bus.rsp_tready = 1'($urandom); drive_spurious(); step();
        end
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
